// File: rtl/cgra_thread_injector.sv
// CGRA thread injector: pops dispatch FIFO heads into 1/2/4-lane issue bundles with credit-limited in-flight tracking.
// Optional performance counters are built when INJECTOR_PERF_CNT_EN is defined.
module cgra_thread_injector_lane #(
  parameter int TID_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lane_en,
  input  logic             head_valid,
  input  logic [TID_W-1:0] head_tid,
  input  logic             capture,
  output logic             pop,
  output logic [TID_W-1:0] tid_q,
  output logic             mask_q
);
  logic take;
  assign take = lane_en & head_valid;
  assign pop  = capture & take;

  // Lanes not taken in a bundle carry TID 0 so the fabric never sees stale IDs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tid_q  <= '0;
      mask_q <= 1'b0;
    end else if (capture) begin
      tid_q  <= take ? head_tid : '0;
      mask_q <= take;
    end
  end
endmodule

module cgra_thread_injector #(
  parameter int MAX_INFLIGHT = 8,
  parameter int TID_W        = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         unrolling_factor,
  input  logic [TID_W-1:0]   dispatch_tid_0,
  input  logic [TID_W-1:0]   dispatch_tid_1,
  input  logic [TID_W-1:0]   dispatch_tid_2,
  input  logic [TID_W-1:0]   dispatch_tid_3,
  input  logic               dispatch_valid_0,
  input  logic               dispatch_valid_1,
  input  logic               dispatch_valid_2,
  input  logic               dispatch_valid_3,
  input  logic               dispatcher_busy,
  input  logic               dispatcher_done,
  output logic [3:0]         dispatch_fifo_pop,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [4*TID_W-1:0] issue_tid,
  output logic [3:0]         issue_lane_mask,
  input  logic               cgra_retire_valid,
  output logic               injector_busy,
  output logic               injector_done,
  output logic               retire_underflow_err,
  output logic [31:0]        perf_bundles,
  output logic [31:0]        perf_stall_credit,
  output logic [31:0]        perf_stall_bubble
);
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                             state;
  logic [1:0]                         uf_q;
  logic [NUM_LANES-1:0]               lane_en, head_vld, en_vld;
  logic [NUM_LANES-1:0][TID_W-1:0]    head_tid, tid_q;
  logic [CNT_W-1:0]                   inflight;
  logic                               slot_free, retire_ok, credit_ok, data_ok, capture;

  assign head_vld = {dispatch_valid_3, dispatch_valid_2, dispatch_valid_1, dispatch_valid_0};
  assign head_tid = {dispatch_tid_3, dispatch_tid_2, dispatch_tid_1, dispatch_tid_0};

  always_comb begin
    case (uf_q)
      2'b00:   lane_en = 4'b0001;
      2'b01:   lane_en = 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  assign en_vld    = head_vld & lane_en;
  assign slot_free = !issue_valid || issue_ready;
  // A retire in the same cycle frees the credit the capture needs.
  assign retire_ok = cgra_retire_valid && (inflight != '0);
  assign credit_ok = (inflight < CNT_W'(MAX_INFLIGHT)) || retire_ok;
  assign data_ok   = (en_vld == lane_en) || (dispatcher_done && (en_vld != '0));
  assign capture   = (state == S_ISSUE) && slot_free && credit_ok && data_ok;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    cgra_thread_injector_lane #(.TID_W(TID_W)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .lane_en    (lane_en[i]),
      .head_valid (head_vld[i]),
      .head_tid   (head_tid[i]),
      .capture    (capture),
      .pop        (dispatch_fifo_pop[i]),
      .tid_q      (tid_q[i]),
      .mask_q     (issue_lane_mask[i])
    );
  end
  assign issue_tid = tid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      uf_q          <= 2'b00;
      injector_busy <= 1'b0;
      injector_done <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (dispatcher_busy) begin
          state         <= S_ISSUE;
          uf_q          <= unrolling_factor;
          injector_busy <= 1'b1;
        end
        S_ISSUE: if (dispatcher_done && (en_vld == '0) && !issue_valid) state <= S_DRAIN;
        S_DRAIN: if (inflight == '0) begin
          state         <= S_DONE;
          injector_busy <= 1'b0;
          injector_done <= 1'b1;
        end
        S_DONE: begin
          state         <= S_IDLE;
          injector_done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid          <= 1'b0;
      inflight             <= '0;
      retire_underflow_err <= 1'b0;
    end else begin
      if (capture)          issue_valid <= 1'b1;
      else if (issue_ready) issue_valid <= 1'b0;
      case ({capture, retire_ok})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      if (cgra_retire_valid && (inflight == '0)) retire_underflow_err <= 1'b1;
    end
  end

`ifdef INJECTOR_PERF_CNT_EN
  logic start, stall_credit, stall_bubble;
  assign start        = (state == S_IDLE) && dispatcher_busy;
  assign stall_credit = (state == S_ISSUE) && slot_free && data_ok && !credit_ok;
  assign stall_bubble = (state == S_ISSUE) && !issue_valid && !capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bundles      <= '0;
      perf_stall_credit <= '0;
      perf_stall_bubble <= '0;
    end else if (start) begin
      perf_bundles      <= '0;
      perf_stall_credit <= '0;
      perf_stall_bubble <= '0;
    end else begin
      if (capture && perf_bundles != '1)           perf_bundles      <= perf_bundles + 32'd1;
      if (stall_credit && perf_stall_credit != '1) perf_stall_credit <= perf_stall_credit + 32'd1;
      if (stall_bubble && perf_stall_bubble != '1) perf_stall_bubble <= perf_stall_bubble + 32'd1;
    end
  end
`else
  assign perf_bundles      = '0;
  assign perf_stall_credit = '0;
  assign perf_stall_bubble = '0;
`endif
endmodule
